// File: rtl/mmio_responder.sv
// Memory-mapped responder for a 16-byte bus window: LED register, synchronised
// switches, display FIFO with a valid/ready drain, sticky status and a prescaled timer.
module mmio_responder #(
    parameter logic [7:0] BASE       = 8'hF0,
    parameter int         FIFO_DEPTH = 4,
    parameter int         PRESCALE   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       rden,
    input  logic       wren,
    output logic [7:0] rdata,
    output logic       hit,
    input  logic [7:0] sw_in,
    output logic [7:0] led_out,
    output logic [7:0] disp_data,
    output logic       disp_valid,
    input  logic       disp_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic          sel;
    logic          wr_acc;
    logic          rd_acc;
    logic [3:0]    reg_sel;
    logic [7:0]    sw_meta;
    logic [7:0]    sw_sync;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          ovf;
    logic          twrap;
    logic          stat_wr;
    logic [7:0]    timer;
    logic [PW-1:0] presc;
    logic          tick;
    logic          timer_wr;
    logic          wrap_evt;
    logic [7:0]    status;
    logic [7:0]    rd_val;

    assign sel     = (addr[7:4] == BASE[7:4]);
    assign reg_sel = addr[3:0];
    assign wr_acc  = wren && sel;
    assign rd_acc  = rden && !wren && sel;

    // The extra pointer bit tells full from empty when the indices coincide.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push       = wr_acc && (reg_sel == 4'd2);
    assign pop        = !empty && disp_ready;
    assign disp_valid = !empty;
    assign disp_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    assign stat_wr  = wr_acc && (reg_sel == 4'd3);
    assign timer_wr = wr_acc && (reg_sel == 4'd4);
    assign tick     = (presc == PRESC_LAST);
    assign wrap_evt = tick && !timer_wr && (timer == 8'hFF);
    assign status   = {4'b0000, twrap, ovf, full, empty};

    always_comb begin
        rd_val = 8'h00;
        case (reg_sel)
            4'd0:    rd_val = led_out;
            4'd1:    rd_val = sw_sync;
            4'd3:    rd_val = status;
            4'd4:    rd_val = timer;
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit     <= 1'b0;
            rdata   <= 8'h00;
            led_out <= 8'h00;
            sw_meta <= 8'h00;
            sw_sync <= 8'h00;
        end else begin
            hit     <= rd_acc;
            rdata   <= rd_acc ? rd_val : 8'h00;
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (wr_acc && (reg_sel == 4'd0)) begin
                led_out <= data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    // A push is judged on the pre-edge fill level, so a same-cycle pop never rescues it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Set events win over a same-cycle clear write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf   <= 1'b0;
            twrap <= 1'b0;
        end else begin
            if (push && full) begin
                ovf <= 1'b1;
            end else if (stat_wr && data_in[2]) begin
                ovf <= 1'b0;
            end
            if (wrap_evt) begin
                twrap <= 1'b1;
            end else if (stat_wr && data_in[3]) begin
                twrap <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= 8'h00;
            presc <= '0;
        end else if (timer_wr) begin
            timer <= data_in;
            presc <= '0;
        end else if (tick) begin
            timer <= timer + 8'd1;
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed register/FIFO/timer scenarios plus randomized bus
// traffic compared every cycle against a queue-and-arithmetic model of the window.
module tb_mmio_responder;
    localparam int FD = 4;
    localparam int PS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       rden = 1'b0;
    logic       wren = 1'b0;
    logic [7:0] sw_in = 8'h00;
    logic       disp_ready = 1'b0;
    logic [7:0] rdata;
    logic       hit;
    logic [7:0] led_out;
    logic [7:0] disp_data;
    logic       disp_valid;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_led = 8'h00;
    logic [7:0] m_sw1 = 8'h00;
    logic [7:0] m_sw2 = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    logic       m_hit = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_twrap = 1'b0;
    int         t_load = 0;
    int         t_cyc = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];

    mmio_responder #(.BASE(8'hF0), .FIFO_DEPTH(FD), .PRESCALE(PS)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rden(rden), .wren(wren),
        .rdata(rdata), .hit(hit), .sw_in(sw_in), .led_out(led_out),
        .disp_data(disp_data), .disp_valid(disp_valid), .disp_ready(disp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Timer value is the load value plus whole prescale periods elapsed since the load.
    function automatic logic [7:0] m_timer();
        return 8'((t_load + t_cyc / PS) % 256);
    endfunction

    function automatic logic [7:0] m_status();
        return {4'b0000, m_twrap, m_ovf, (mq.size() == FD), (mq.size() == 0)};
    endfunction

    task automatic model_step();
        logic [7:0] rv;
        int  t0;
        int  t1;
        bit  s;
        bit  w;
        bit  r;
        bit  was_full;
        bit  push_n;
        bit  pop_n;
        bit  wrap_n;
        if (!rst) begin
            m_led = 8'h00; m_sw1 = 8'h00; m_sw2 = 8'h00;
            m_rdata = 8'h00; m_hit = 1'b0; m_ovf = 1'b0; m_twrap = 1'b0;
            t_load = 0; t_cyc = 0;
            mq.delete();
            return;
        end
        s = (addr[7:4] == 4'hF);
        w = wren && s;
        r = rden && !wren && s;
        case (addr[3:0])
            4'h0:    rv = m_led;
            4'h1:    rv = m_sw2;
            4'h3:    rv = m_status();
            4'h4:    rv = m_timer();
            default: rv = 8'h00;
        endcase
        m_hit   = r;
        m_rdata = r ? rv : 8'h00;
        was_full = (mq.size() == FD);
        push_n   = w && (addr[3:0] == 4'd2);
        pop_n    = (mq.size() > 0) && disp_ready;
        t0 = t_load + t_cyc / PS;
        t1 = t_load + (t_cyc + 1) / PS;
        wrap_n = 1'b0;
        if (w && (addr[3:0] == 4'd4)) begin
            t_load = int'(data_in);
            t_cyc  = 0;
        end else begin
            wrap_n = (t1 != t0) && ((t0 % 256) == 255);
            t_cyc++;
        end
        if (w && (addr[3:0] == 4'd3)) begin
            if (data_in[2]) m_ovf = 1'b0;
            if (data_in[3]) m_twrap = 1'b0;
        end
        if (push_n && was_full) m_ovf = 1'b1;
        if (wrap_n) m_twrap = 1'b1;
        if (pop_n) void'(mq.pop_front());
        if (push_n && !was_full) mq.push_back(data_in);
        if (w && (addr[3:0] == 4'd0)) m_led = data_in;
        m_sw2 = m_sw1;
        m_sw1 = sw_in;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("cyc_hit", {7'b0, hit}, {7'b0, m_hit});
            check("cyc_rdata", rdata, m_rdata);
            check("cyc_led", led_out, m_led);
            check("cyc_valid", {7'b0, disp_valid}, (mq.size() > 0) ? 8'h01 : 8'h00);
            if (mq.size() > 0) check("cyc_head", disp_data, mq[0]);
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; data_in = d; wren = 1'b1; rden = 1'b0;
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        addr = a; rden = 1'b1; wren = 1'b0;
        @(negedge clk);
        check({name, "_hit"}, {7'b0, hit}, 8'h01);
        check(name, rdata, exp);
        rden = 1'b0;
    endtask

    task automatic drain();
        disp_ready = 1'b1;
        foreach (exp_q[i]) begin
            check("drain_valid", {7'b0, disp_valid}, 8'h01);
            check("drain_data", disp_data, exp_q[i]);
            @(negedge clk);
        end
        check("drain_empty", {7'b0, disp_valid}, 8'h00);
        disp_ready = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rdata"}, rdata, 8'h00);
        check({tag, "_hit"}, {7'b0, hit}, 8'h00);
        check({tag, "_led"}, led_out, 8'h00);
        check({tag, "_valid"}, {7'b0, disp_valid}, 8'h00);
        check({tag, "_data"}, disp_data, 8'h00);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b1;
        rd_chk("status_after_reset", 8'hF3, 8'h01);

        wr(8'hF0, 8'hA5);
        check("led_write", led_out, 8'hA5);
        sw_in = 8'h3C;
        repeat (3) @(negedge clk);
        rd_chk("sw_read", 8'hF1, 8'h3C);
        addr = 8'h80; rden = 1'b1;
        @(negedge clk);
        check("miss_hit", {7'b0, hit}, 8'h00);
        check("miss_rdata", rdata, 8'h00);
        rden = 1'b0;

        wr(8'hF2, 8'h11); wr(8'hF2, 8'h22); wr(8'hF2, 8'h33); wr(8'hF2, 8'h44);
        rd_chk("status_full", 8'hF3, 8'h02);
        wr(8'hF2, 8'h55);
        rd_chk("status_ovf", 8'hF3, 8'h06);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain();
        wr(8'hF3, 8'h04);
        rd_chk("status_ovf_clr", 8'hF3, 8'h01);

        wr(8'hF2, 8'h61); wr(8'hF2, 8'h62);
        disp_ready = 1'b1;
        wr(8'hF2, 8'h77);
        disp_ready = 1'b0;
        rd_chk("status_two", 8'hF3, 8'h00);
        exp_q = '{8'h62, 8'h77};
        drain();

        wr(8'hF2, 8'hA1); wr(8'hF2, 8'hA2); wr(8'hF2, 8'hA3); wr(8'hF2, 8'hA4);
        rd_chk("status_full2", 8'hF3, 8'h02);
        disp_ready = 1'b1;
        wr(8'hF2, 8'h99);
        disp_ready = 1'b0;
        rd_chk("status_full_pop", 8'hF3, 8'h04);
        exp_q = '{8'hA2, 8'hA3, 8'hA4};
        drain();
        wr(8'hF3, 8'h04);

        addr = 8'hF0; data_in = 8'h5A; rden = 1'b1; wren = 1'b1;
        @(negedge clk);
        check("prio_led", led_out, 8'h5A);
        check("prio_hit", {7'b0, hit}, 8'h00);
        rden = 1'b0; wren = 1'b0;

        wr(8'hF4, 8'hFE);
        repeat (4) @(negedge clk);
        rd_chk("timer_wrapped", 8'hF4, 8'h00);
        rd_chk("status_twrap", 8'hF3, 8'h09);
        wr(8'hF3, 8'h08);
        rd_chk("status_twrap_clr", 8'hF3, 8'h01);
        wr(8'hF4, 8'hFF);
        @(negedge clk);
        wr(8'hF3, 8'h08);
        rd_chk("status_clr_vs_wrap", 8'hF3, 8'h09);
        wr(8'hF3, 8'h08);
        rd_chk("status_clean", 8'hF3, 8'h01);

        wr(8'hF2, 8'hC1); wr(8'hF2, 8'hC2);
        addr = 8'hF0; rden = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_zero_outputs("async_reset");
        @(negedge clk);
        rden = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd_chk("status_after_midreset", 8'hF3, 8'h01);

        for (int i = 0; i < 3000; i++) begin
            addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {4'hF, 4'($urandom_range(0, 6))};
            data_in = 8'($urandom);
            wren = ($urandom_range(0, 3) == 0);
            rden = ($urandom_range(0, 2) == 0);
            disp_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) sw_in = 8'($urandom);
            @(negedge clk);
        end
        rden = 1'b0; wren = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
